lsu_mem_ctrl: RTL

Load/store unit sitting between the core's execute stage and the word-indexed data memory. It accepts one byte/halfword/word load or store request at a time. It translates the byte address into a word index, performs read-modify-write for subword stores, and sign- or zero-extends load data. It also flags misaligned, illegal or out-of-range accesses without touching memory.

---
 rtl/lsu_mem_ctrl.sv | 93 +++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: single-outstanding load/store unit with subword read-modify-write and access checks
module lsu_mem_ctrl #(
    parameter int MEM_WORDS = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic        resp_err_o,
    output logic [31:0] resp_rdata_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_w_en_o,
    input  logic [31:0] mem_rdata_i
);
    typedef enum logic [2:0] {IDLE, LOAD, STORE_W, RMW_RD, RMW_WR, RESP} state_t;
    localparam logic [29:0] LIMIT = 30'(MEM_WORDS);
    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q, word_q, rdata_q;
    logic [2:0]  funct3_q;
    logic        err_q;
    logic        illegal, misaligned, out_of_range, req_err, accept;
    logic [15:0] lane;
    logic [31:0] mask, merged, ext;
    logic [4:0]  sh;

    always_comb begin
        illegal = req_we_i ? (req_funct3_i[2] || req_funct3_i[1:0] == 2'b11)
                           : (req_funct3_i[1:0] == 2'b11 || req_funct3_i == 3'b110);
        misaligned = (req_funct3_i[0] && req_addr_i[0]) || (req_funct3_i[1] && req_addr_i[1:0] != 2'b00);
        out_of_range = req_addr_i[31:2] >= LIMIT;
        req_err = illegal || misaligned || out_of_range;
        accept = req_valid_i && state_q == IDLE;
        sh = {addr_q[1:0], 3'b000};
        lane = 16'(mem_rdata_i >> sh);
        ext = funct3_q[1] ? mem_rdata_i
            : funct3_q[0] ? {{16{lane[15] & ~funct3_q[2]}}, lane}
            : {{24{lane[7] & ~funct3_q[2]}}, lane[7:0]};
        mask = funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF;
        merged = (word_q & ~(mask << sh)) | ((wdata_q & mask) << sh);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = !accept ? IDLE : req_err ? RESP : !req_we_i ? LOAD
                             : req_funct3_i == 3'b010 ? STORE_W : RMW_RD;
            LOAD:    state_d = RESP;
            STORE_W: state_d = RESP;
            RMW_RD:  state_d = RMW_WR;
            RMW_WR:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            word_q   <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q   <= req_addr_i;
                funct3_q <= req_funct3_i;
                wdata_q  <= req_wdata_i;
            end
            if (state_q == RMW_RD) word_q <= mem_rdata_i;
            if (state_d == RESP) begin
                err_q   <= state_q == IDLE;
                rdata_q <= state_q == LOAD ? ext : '0;
            end
        end
    end

    assign req_ready_o  = state_q == IDLE;
    assign resp_valid_o = state_q == RESP;
    assign resp_err_o   = err_q;
    assign resp_rdata_o = rdata_q;
    assign mem_addr_o   = {2'b00, addr_q[31:2]};
    assign mem_w_en_o   = state_q == STORE_W || state_q == RMW_WR;
    assign mem_wdata_o  = state_q == STORE_W ? wdata_q : state_q == RMW_WR ? merged : '0;
endmodule
